// File: rtl/nx_fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among NREQ valid/ready requesters.
// A grant is held until the owner's last beat or MAX_BURST beats; each beat carries its owner tag.
module nx_fifo_wr_arb #(
   parameter  int NREQ      = 4,
   parameter  int WIDTH     = 128,
   parameter  int MAX_BURST = 4,
   localparam int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ-1:0]         req_last,
   input  logic [NREQ*WIDTH-1:0]   req_data,
   output logic [NREQ-1:0]         req_ready,
   input  logic                    fifo_full,
   output logic                    fifo_wen,
   output logic [WIDTH-1:0]        fifo_wdata,
   output logic [IDW-1:0]          fifo_wtag,
   output logic                    fifo_wlast,
   output logic [IDW-1:0]          owner,
   output logic                    busy
);

   localparam int              CNTW     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CNTW-1:0] CAP_LAST = (MAX_BURST > 0) ? CNTW'(MAX_BURST - 1) : '0;
   localparam logic            HAS_CAP  = (MAX_BURST != 0);
   localparam logic [IDW-1:0]  LAST_ID  = IDW'(NREQ - 1);

   typedef enum logic {
      ST_IDLE,
      ST_LOCK
   } state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]   owner_q, owner_d;
   logic [CNTW-1:0]  beat_cnt_q, beat_cnt_d;

   logic [WIDTH-1:0] data_arr [NREQ];
   logic             pick_found;
   logic [IDW-1:0]   pick_idx;
   logic [IDW-1:0]   cand_id;
   int               cand;
   logic             lock;
   logic             accept;
   logic             cap_hit;
   logic             release_grant;

   for (genvar i = 0; i < NREQ; i++) begin : g_split
      assign data_arr[i] = req_data[i*WIDTH +: WIDTH];
   end

   // Cyclic search for the first valid requester at or above rr_ptr.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      cand_id    = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand    = (int'(rr_ptr_q) + k) % NREQ;
         cand_id = IDW'(cand);
         if (!pick_found && req_valid[cand_id]) begin
            pick_found = 1'b1;
            pick_idx   = cand_id;
         end
      end
   end

   assign lock          = (state_q == ST_LOCK);
   assign accept        = lock & ~rst & req_valid[owner_q] & ~fifo_full;
   assign cap_hit       = HAS_CAP && (beat_cnt_q == CAP_LAST);
   assign release_grant = accept & (req_last[owner_q] | cap_hit);

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      beat_cnt_d = beat_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               owner_d    = pick_idx;
               beat_cnt_d = '0;
               state_d    = ST_LOCK;
            end
         end
         ST_LOCK: begin
            if (accept) begin
               beat_cnt_d = beat_cnt_q + CNTW'(1);
            end
            if (release_grant) begin
               // The releasing requester drops to lowest priority.
               rr_ptr_d = (owner_q == LAST_ID) ? '0 : owner_q + IDW'(1);
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   always_comb begin
      req_ready = '0;
      if (accept) begin
         req_ready[owner_q] = 1'b1;
      end
   end

   assign fifo_wen   = accept;
   assign fifo_wdata = lock ? data_arr[owner_q] : '0;
   assign fifo_wtag  = lock ? owner_q : '0;
   assign fifo_wlast = lock & req_last[owner_q];
   assign owner      = owner_q;
   assign busy       = lock;

endmodule

// File: tb/tb_nx_fifo_wr_arb.sv
// Bench for nx_fifo_wr_arb: directed vector table for the arbitration corner cases,
// then randomized traffic checked against a transaction-level reference model.
module tb_nx_fifo_wr_arb;

   localparam int NREQ  = 4;
   localparam int WIDTH = 32;
   localparam int MAXB  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_last;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]   req_ready;
   logic              fifo_full;
   logic              fifo_wen;
   logic [WIDTH-1:0]  fifo_wdata;
   logic [1:0]        fifo_wtag;
   logic              fifo_wlast;
   logic [1:0]        owner;
   logic              busy;

   int n_cmp = 0;
   int n_bad = 0;

   nx_fifo_wr_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(MAXB)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
      .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wen(fifo_wen),
      .fifo_wdata(fifo_wdata), .fifo_wtag(fifo_wtag), .fifo_wlast(fifo_wlast),
      .owner(owner), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [3:0] v;
      logic [3:0] l;
      logic       f;
      logic       chk;
      logic [3:0] e_rdy;
      logic       e_wen;
      logic [1:0] e_tag;
      logic       e_last;
      logic       e_busy;
      logic [1:0] e_own;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic r, logic [3:0] v, logic [3:0] l, logic f,
                               logic [3:0] rdy, logic wen, logic [1:0] tag,
                               logic lst, logic bsy, logic [1:0] own);
      vec_t x;
      x.rst = r; x.v = v; x.l = l; x.f = f; x.chk = ~r;
      x.e_rdy = rdy; x.e_wen = wen; x.e_tag = tag; x.e_last = lst;
      x.e_busy = bsy; x.e_own = own;
      return x;
   endfunction

   function automatic logic [WIDTH-1:0] pat(int i);
      return 32'hA5A5_0000 | WIDTH'(i);
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   logic [WIDTH-1:0] dat [NREQ];
   int rem [NREQ];
   int seq [NREQ];
   int tseq [6] = '{0, 1, 2, 3, 0, 1};

   // reference model state
   bit m_busy;
   int m_own, m_rr, m_beats;

   initial begin
      logic [3:0] e_rdy;
      logic       e_wen, e_last;
      int         e_tag;
      logic [WIDTH-1:0] e_data;
      bit         do_rst;
      int         prev;

      // Reset state
      rst = 1'b1; req_valid = 4'hF; req_last = 4'hF; fifo_full = 1'b0;
      for (int i = 0; i < NREQ; i++) dat[i] = pat(i);
      req_data = {dat[3], dat[2], dat[1], dat[0]};
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0; req_valid = 4'h0;
      #1;
      chk("rst.ready", req_ready, 0);
      chk("rst.wen",   fifo_wen, 0);
      chk("rst.busy",  busy, 0);
      chk("rst.owner", owner, 0);
      chk("rst.wtag",  fifo_wtag, 0);
      chk("rst.wlast", fifo_wlast, 0);
      chk("rst.wdata", fifo_wdata, 0);
      @(posedge clk); #1;

      // Arbitration order 0 then 2, then rr wraps from 3
      tbl.push_back(mk(0, 4'b0101, 4'hF, 0, 4'b0000, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4'b0101, 4'hF, 0, 4'b0001, 1, 0, 1, 1, 0));
      tbl.push_back(mk(0, 4'b0101, 4'hF, 0, 4'b0000, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4'b0101, 4'hF, 0, 4'b0100, 1, 2, 1, 1, 2));
      tbl.push_back(mk(0, 4'b0000, 4'hF, 0, 4'b0000, 0, 0, 0, 0, 2));
      tbl.push_back(mk(0, 4'b1111, 4'hF, 0, 4'b0000, 0, 0, 0, 0, 2));
      tbl.push_back(mk(0, 4'b1111, 4'hF, 0, 4'b1000, 1, 3, 1, 1, 3));
      tbl.push_back(mk(0, 4'b0000, 4'h0, 0, 4'b0000, 0, 0, 0, 0, 3));
      // Full back-pressure on req1 3-beat packet, plus a valid drop mid-packet
      tbl.push_back(mk(0, 4'b0010, 4'h0, 0, 4'b0000, 0, 0, 0, 0, 3));
      tbl.push_back(mk(0, 4'b0010, 4'h0, 0, 4'b0010, 1, 1, 0, 1, 1));
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(0, 4'b0010, 4'h0, 1, 4'b0000, 0, 1, 0, 1, 1));
      tbl.push_back(mk(0, 4'b0010, 4'h0, 0, 4'b0010, 1, 1, 0, 1, 1));
      tbl.push_back(mk(0, 4'b0000, 4'h0, 0, 4'b0000, 0, 1, 0, 1, 1));
      tbl.push_back(mk(0, 4'b0010, 4'b0010, 0, 4'b0010, 1, 1, 1, 1, 1));
      tbl.push_back(mk(1, 4'b0000, 4'h0, 0, 0, 0, 0, 0, 0, 0));
      // Burst cap: req1 6 beats cut after 4, req3 single beat in between
      tbl.push_back(mk(0, 4'b1010, 4'b1000, 0, 4'b0000, 0, 0, 0, 0, 0));
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(0, 4'b1010, 4'b1000, 0, 4'b0010, 1, 1, 0, 1, 1));
      tbl.push_back(mk(0, 4'b1010, 4'b1000, 0, 4'b0000, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 4'b1010, 4'b1000, 0, 4'b1000, 1, 3, 1, 1, 3));
      tbl.push_back(mk(0, 4'b0010, 4'h0, 0, 4'b0000, 0, 0, 0, 0, 3));
      tbl.push_back(mk(0, 4'b0010, 4'h0, 0, 4'b0010, 1, 1, 0, 1, 1));
      tbl.push_back(mk(0, 4'b0010, 4'b0010, 0, 4'b0010, 1, 1, 1, 1, 1));
      tbl.push_back(mk(1, 4'b0000, 4'h0, 0, 0, 0, 0, 0, 0, 0));
      // Fairness: all requesting, single-beat packets
      prev = 0;
      for (int i = 0; i < 6; i++) begin
         tbl.push_back(mk(0, 4'hF, 4'hF, 0, 4'b0000, 0, 0, 0, 0, 2'(prev)));
         tbl.push_back(mk(0, 4'hF, 4'hF, 0, 4'(1 << tseq[i]), 1, 2'(tseq[i]), 1, 1, 2'(tseq[i])));
         prev = tseq[i];
      end
      // Reset mid-burst of req2 4-beat packet; req0 then wins
      tbl.push_back(mk(0, 4'b0100, 4'h0, 0, 4'b0000, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 4'b0100, 4'h0, 0, 4'b0100, 1, 2, 0, 1, 2));
      tbl.push_back(mk(1, 4'b0100, 4'h0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4'b0101, 4'b0101, 0, 4'b0000, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4'b0101, 4'b0101, 0, 4'b0001, 1, 0, 1, 1, 0));

      foreach (tbl[i]) begin
         rst = tbl[i].rst; req_valid = tbl[i].v; req_last = tbl[i].l; fifo_full = tbl[i].f;
         #1;
         if (tbl[i].chk) begin
            chk($sformatf("v%0d.ready", i), req_ready, tbl[i].e_rdy);
            chk($sformatf("v%0d.wen",   i), fifo_wen,  tbl[i].e_wen);
            chk($sformatf("v%0d.wtag",  i), fifo_wtag, tbl[i].e_tag);
            chk($sformatf("v%0d.wlast", i), fifo_wlast, tbl[i].e_last);
            chk($sformatf("v%0d.busy",  i), busy,      tbl[i].e_busy);
            chk($sformatf("v%0d.owner", i), owner,     tbl[i].e_own);
            chk($sformatf("v%0d.wdata", i), fifo_wdata,
                tbl[i].e_busy ? pat(int'(tbl[i].e_own)) : '0);
         end
         @(posedge clk); #1;
      end

      // Randomized traffic against the reference model
      rst = 1'b1; req_valid = '0; fifo_full = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      m_busy = 0; m_own = 0; m_rr = 0; m_beats = 0;
      for (int i = 0; i < NREQ; i++) begin rem[i] = 0; seq[i] = 0; end

      for (int cyc = 0; cyc < 3000; cyc++) begin
         do_rst = ($urandom_range(0, 199) == 0);
         for (int i = 0; i < NREQ; i++) begin
            if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 7);
            req_valid[i] = (rem[i] != 0) && ($urandom_range(0, 9) < 7);
            req_last[i]  = (rem[i] == 1);
            dat[i] = {8'(i), 24'(seq[i])};
         end
         req_data  = {dat[3], dat[2], dat[1], dat[0]};
         fifo_full = ($urandom_range(0, 3) == 0);
         rst = do_rst;
         #1;

         e_rdy = '0; e_wen = 0; e_tag = 0; e_last = 0; e_data = '0;
         if (m_busy) begin
            e_wen  = req_valid[m_own] && !fifo_full;
            if (e_wen) e_rdy[m_own] = 1'b1;
            e_tag  = m_own;
            e_last = req_last[m_own];
            e_data = dat[m_own];
         end
         if (!do_rst) begin
            chk($sformatf("r%0d.ready", cyc), req_ready, e_rdy);
            chk($sformatf("r%0d.wen",   cyc), fifo_wen, e_wen);
            chk($sformatf("r%0d.wtag",  cyc), fifo_wtag, e_tag);
            chk($sformatf("r%0d.wlast", cyc), fifo_wlast, e_last);
            chk($sformatf("r%0d.wdata", cyc), fifo_wdata, e_data);
            chk($sformatf("r%0d.busy",  cyc), busy, m_busy);
            chk($sformatf("r%0d.owner", cyc), owner, m_own);
         end

         if (do_rst) begin
            m_busy = 0; m_own = 0; m_rr = 0; m_beats = 0;
         end else begin
            for (int i = 0; i < NREQ; i++)
               if (e_rdy[i]) begin rem[i]--; seq[i]++; end
            if (m_busy) begin
               if (e_wen) begin
                  m_beats++;
                  if (req_last[m_own] || (MAXB != 0 && m_beats == MAXB)) begin
                     m_busy = 0;
                     m_rr   = (m_own + 1) % NREQ;
                  end
               end
            end else if (req_valid != 0) begin
               for (int k = NREQ - 1; k >= 0; k--)
                  if (req_valid[(m_rr + k) % NREQ]) m_own = (m_rr + k) % NREQ;
               m_busy  = 1;
               m_beats = 0;
            end
         end
         @(posedge clk); #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
